// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480@60 timing constants and window helper
package vga_pkg;

  localparam int CNT_W     = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // True when pos lies in the half-open window [lo, hi)
  function automatic logic in_span(input logic [CNT_W-1:0] pos,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - wrap-at-max counter with enable, next-value and wrap strobe
module mod_counter
  import vga_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] max_val,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  // Wrap strobe is combinational so the caller can chain the next counter on the same edge
  assign wrap       = en && (count == max_val);
  assign count_next = !en ? count : (wrap ? '0 : count + W'(1));

  // Reset parks the counter at its maximum so the first enabled step lands on zero
  always_ff @(posedge clk) begin
    if (!rst_n) count <= max_val;
    else        count <= count_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: position counters, syncs, visible flag, ticks
module vga_timing_gen #(
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [9:0] frame_count
);

  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_wrap;
  logic       v_wrap;

  mod_counter #(.W(10)) u_hcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ce),
    .max_val    (H_MAX),
    .count      (hpos),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  // Vertical counter steps only when the horizontal one wraps (h_wrap already includes ce)
  mod_counter #(.W(10)) u_vcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (h_wrap),
    .max_val    (V_MAX),
    .count      (vpos),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decoded outputs are registered from the counters' next values so they align with hpos/vpos
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      visible     <= 1'b0;
      line_tick   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      line_tick  <= h_wrap;
      frame_tick <= v_wrap;
      if (ce) begin
        hsync       <= vga_pkg::in_span(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync       <= vga_pkg::in_span(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        visible     <= (h_next < H_VIS) && (v_next < V_VIS);
        frame_count <= frame_count + 10'(v_wrap);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (full-size and shrunken rasters)
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] f_hpos, f_vpos, f_frame_count;
  logic       f_hsync, f_vsync, f_visible, f_line_tick, f_frame_tick;
  logic [9:0] s_hpos, s_vpos, s_frame_count;
  logic       s_hsync, s_vsync, s_visible, s_line_tick, s_frame_tick;

  vga_timing_gen u_full (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .hpos(f_hpos), .vpos(f_vpos), .hsync(f_hsync), .vsync(f_vsync),
    .visible(f_visible), .line_tick(f_line_tick), .frame_tick(f_frame_tick),
    .frame_count(f_frame_count)
  );

  // 8 clocks per line, 4 lines per frame: hsync at h 5..6, vsync at line 2, visible h<4 && v<1
  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .hpos(s_hpos), .vpos(s_vpos), .hsync(s_hsync), .vsync(s_vsync),
    .visible(s_visible), .line_tick(s_line_tick), .frame_tick(s_frame_tick),
    .frame_count(s_frame_count)
  );

  typedef struct packed {
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       line_tick;
    logic       frame_tick;
    logic [9:0] frame_count;
  } obs_t;

  typedef struct {
    bit   ce;
    bit   rst_n;
    obs_t exp;
  } vec_t;

  obs_t act_f, act_s;
  assign act_f = {f_hpos, f_vpos, f_hsync, f_vsync, f_visible, f_line_tick, f_frame_tick, f_frame_count};
  assign act_s = {s_hpos, s_vpos, s_hsync, s_vsync, s_visible, s_line_tick, s_frame_tick, s_frame_count};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  int m_h[2], m_v[2], m_fc[2];
  bit m_lt[2], m_ft[2];
  obs_t q_f[$], q_s[$];

  function automatic string fmt(input obs_t o);
    return $sformatf("h=%0d v=%0d hs=%0b vs=%0b vis=%0b lt=%0b ft=%0b fc=%0d",
                     o.hpos, o.vpos, o.hsync, o.vsync, o.visible, o.line_tick, o.frame_tick, o.frame_count);
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference raster: config 0 is the full 800x525 mode, config 1 the shrunken 8x4 mode
  function automatic obs_t model_obs(input int c);
    obs_t o;
    int h, v, hs_lo, hs_hi, vs_lo, vs_hi, hd, vd;
    h = m_h[c];
    v = m_v[c];
    if (c == 0) begin
      hs_lo = 656; hs_hi = 751; vs_lo = 490; vs_hi = 491; hd = 640; vd = 480;
    end else begin
      hs_lo = 5; hs_hi = 6; vs_lo = 2; vs_hi = 2; hd = 4; vd = 1;
    end
    o.hpos        = 10'(h);
    o.vpos        = 10'(v);
    o.hsync       = !(h >= hs_lo && h <= hs_hi);
    o.vsync       = !(v >= vs_lo && v <= vs_hi);
    o.visible     = (h < hd) && (v < vd);
    o.line_tick   = m_lt[c];
    o.frame_tick  = m_ft[c];
    o.frame_count = 10'(m_fc[c]);
    return o;
  endfunction

  task automatic model_step(input int c, input bit ce_v, input bit rst_v);
    int ht, vt;
    ht = (c == 0) ? 800 : 8;
    vt = (c == 0) ? 525 : 4;
    if (!rst_v) begin
      m_h[c] = ht - 1; m_v[c] = vt - 1; m_fc[c] = 0; m_lt[c] = 0; m_ft[c] = 0;
    end else begin
      m_lt[c] = 0;
      m_ft[c] = 0;
      if (ce_v) begin
        if (m_h[c] == ht - 1) begin
          m_h[c] = 0;
          m_lt[c] = 1;
          if (m_v[c] == vt - 1) begin
            m_v[c] = 0;
            m_ft[c] = 1;
            m_fc[c] = (m_fc[c] + 1) % 1024;
          end else begin
            m_v[c] = m_v[c] + 1;
          end
        end else begin
          m_h[c] = m_h[c] + 1;
        end
      end
    end
  endtask

  // One clock: drive inputs, queue the model's prediction, then pop and compare after the edge
  task automatic tick(input bit ce_v, input bit rst_v);
    obs_t e;
    ce = ce_v;
    rst_n = rst_v;
    model_step(0, ce_v, rst_v);
    model_step(1, ce_v, rst_v);
    q_f.push_back(model_obs(0));
    q_s.push_back(model_obs(1));
    @(posedge clk);
    #1;
    cyc++;
    e = q_f.pop_front();
    n_checks++;
    if (act_f !== e) begin
      n_fail++;
      $display("FAIL sb_full cyc=%0d got %s want %s", cyc, fmt(act_f), fmt(e));
    end
    e = q_s.pop_front();
    n_checks++;
    if (act_s !== e) begin
      n_fail++;
      $display("FAIL sb_small cyc=%0d got %s want %s", cyc, fmt(act_s), fmt(e));
    end
  endtask

  function automatic vec_t mk(input bit c, input bit r, input int h, input int v, input bit hs,
                              input bit vs, input bit vis, input bit lt, input bit ft, input int fc);
    vec_t t;
    t.ce = c;
    t.rst_n = r;
    t.exp = {10'(h), 10'(v), hs, vs, vis, lt, ft, 10'(fc)};
    return t;
  endfunction

  vec_t vecs[13];

  initial begin
    int hs_low, hs_first, hs_last, vis_first_low, n_lt, n_ft, last, per, vs_low, consec;
    int fcs[3];
    bit prev_ft, prev_lt, seen;

    // Shrunken raster, hand-derived: reset, hold, first step, ce gaps, hsync window, line wrap
    vecs[0]  = mk(1, 0, 7, 3, 1, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 7, 3, 1, 1, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 1, 1, 1, 1, 1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 1);
    vecs[4]  = mk(1, 1, 1, 0, 1, 1, 1, 0, 0, 1);
    vecs[5]  = mk(1, 1, 2, 0, 1, 1, 1, 0, 0, 1);
    vecs[6]  = mk(1, 1, 3, 0, 1, 1, 1, 0, 0, 1);
    vecs[7]  = mk(1, 1, 4, 0, 1, 1, 0, 0, 0, 1);
    vecs[8]  = mk(1, 1, 5, 0, 0, 1, 0, 0, 0, 1);
    vecs[9]  = mk(0, 1, 5, 0, 0, 1, 0, 0, 0, 1);
    vecs[10] = mk(1, 1, 6, 0, 0, 1, 0, 0, 0, 1);
    vecs[11] = mk(1, 1, 7, 0, 1, 1, 0, 0, 0, 1);
    vecs[12] = mk(1, 1, 0, 1, 1, 1, 0, 1, 0, 1);

    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].ce, vecs[i].rst_n);
      n_checks++;
      if (act_s !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d got %s want %s", i, fmt(act_s), fmt(vecs[i].exp));
      end
    end

    // Full-size first line: sync window, blanking start, one line tick per 800 clocks
    tick(1, 0);
    tick(1, 0);
    hs_low = 0; hs_first = -1; hs_last = -1; vis_first_low = -1; n_lt = 0;
    for (int k = 0; k < 800; k++) begin
      tick(1, 1);
      if (!f_hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(f_hpos);
        hs_last = int'(f_hpos);
      end
      if (!f_visible && vis_first_low < 0) vis_first_low = int'(f_hpos);
      if (f_line_tick) n_lt++;
    end
    check_val("full_hsync_width", hs_low, 96);
    check_val("full_hsync_first", hs_first, 656);
    check_val("full_hsync_last", hs_last, 751);
    check_val("full_blank_start", vis_first_low, 640);
    check_val("full_line_ticks", n_lt, 1);
    tick(1, 1);
    check_val("full_line2_tick", int'(f_line_tick), 1);
    check_val("full_line2_vpos", int'(f_vpos), 1);

    // Shrunken frames with ce held high
    tick(1, 0);
    n_ft = 0; last = -1; per = -1; vs_low = 0;
    for (int k = 1; k <= 65; k++) begin
      tick(1, 1);
      if (s_frame_tick) begin
        if (last >= 0) per = k - last;
        last = k;
        if (n_ft < 3) fcs[n_ft] = int'(s_frame_count);
        n_ft++;
      end
      if (k <= 32 && !s_vsync) vs_low++;
    end
    check_val("frame_ticks", n_ft, 3);
    check_val("frame_period", per, 32);
    check_val("frame_count_2", fcs[1], 2);
    check_val("frame_count_3", fcs[2], 3);
    check_val("vsync_width", vs_low, 8);

    // Shrunken frames with ce alternating: half rate, ticks stay one clock wide
    tick(1, 0);
    n_ft = 0; n_lt = 0; last = -1; per = -1; consec = 0; prev_ft = 0; prev_lt = 0;
    for (int k = 1; k <= 130; k++) begin
      tick(k % 2 == 1, 1);
      if (s_frame_tick) begin
        if (last >= 0) per = k - last;
        last = k;
        n_ft++;
      end
      if (s_line_tick) n_lt++;
      if ((s_frame_tick && prev_ft) || (s_line_tick && prev_lt)) consec++;
      prev_ft = s_frame_tick;
      prev_lt = s_line_tick;
    end
    check_val("ce_frame_period", per, 64);
    check_val("ce_frame_ticks", n_ft, 3);
    check_val("ce_line_ticks", n_lt, 9);
    check_val("ce_tick_width", consec, 0);

    // Mid-frame reset: everything returns to the parked position
    tick(1, 0);
    for (int k = 0; k < 20; k++) tick(1, 1);
    check_val("pre_reset_hpos", int'(s_hpos), 3);
    check_val("pre_reset_vpos", int'(s_vpos), 2);
    tick(1, 0);
    check_val("rst_s_hpos", int'(s_hpos), 7);
    check_val("rst_s_vpos", int'(s_vpos), 3);
    check_val("rst_s_fc", int'(s_frame_count), 0);
    check_val("rst_s_ticks", int'({s_line_tick, s_frame_tick}), 0);
    check_val("rst_f_hpos", int'(f_hpos), 799);
    check_val("rst_f_vpos", int'(f_vpos), 524);
    check_val("rst_f_fc", int'(f_frame_count), 0);
    tick(1, 1);
    check_val("post_rst_f_fc", int'(f_frame_count), 1);
    check_val("post_rst_f_vis", int'(f_visible), 1);

    // Frame counter wrap from 1023 to 0
    for (int k = 0; k < 40000 && s_frame_count != 10'd1023; k++) tick(1, 1);
    check_val("fc_reach_1023", int'(s_frame_count), 1023);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick(1, 1);
      if (s_frame_tick) seen = 1;
    end
    check_val("wrap_tick_seen", int'(seen), 1);
    check_val("fc_wrap", int'(s_frame_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
